// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 divider.
//
// Purpose: divides opdata1_i by opdata2_i, one quotient bit per clock, and
// returns {remainder, quotient} on result_o (remainder in the HI half,
// quotient in the LO half). A zero divisor gives an all-zero result.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   signed_div_i  1 = two's complement division (only with DIV_SIGNED_EN)
//   opdata1_i     dividend, sampled on the accept edge
//   opdata2_i     divisor, sampled on the accept edge
//   start_i       request, held high until the result has been taken
//   annul_i       cancels an operation in flight, blocks acceptance when idle
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
//
// Configuration macro: DIV_SIGNED_EN. When defined, signed_div_i selects a
// signed divide (magnitudes are divided, then the signs are fixed up). When
// undefined, signed_div_i is ignored and every divide is unsigned.
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [DATA_W-1:0]   rem_q;   // partial remainder
  logic [DATA_W-1:0]   quo_q;   // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]   dvsr_q;

  // Operand conditioning and result fix-up
  logic [DATA_W-1:0]   dvnd_mag;
  logic [DATA_W-1:0]   dvsr_mag;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

`ifdef DIV_SIGNED_EN
  logic dvnd_neg;
  logic dvsr_neg;
  logic neg_quo_q;
  logic neg_rem_q;

  assign dvnd_neg = signed_div_i & opdata1_i[DATA_W-1];
  assign dvsr_neg = signed_div_i & opdata2_i[DATA_W-1];
  assign dvnd_mag = dvnd_neg ? (~opdata1_i + 1'b1) : opdata1_i;
  assign dvsr_mag = dvsr_neg ? (~opdata2_i + 1'b1) : opdata2_i;
  // Most-negative dividend keeps its bit pattern as magnitude, which is the
  // correct unsigned value; negating the quotient then wraps as intended.
  assign quo_fix  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix  = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
`else
  logic unused_signed_div;

  assign unused_signed_div = signed_div_i;
  assign dvnd_mag = opdata1_i;
  assign dvsr_mag = opdata2_i;
  assign quo_fix  = quo_q;
  assign rem_fix  = rem_q;
`endif

  // One restoring step. Since rem_q < dvsr_q always holds, the trial
  // difference fits in DATA_W bits when non-negative, so its top bit is a
  // clean borrow flag.
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     trial;
  logic                borrow;
  logic [DATA_W-1:0]   rem_nxt;
  logic [DATA_W-1:0]   quo_nxt;

  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign trial   = shifted - {1'b0, dvsr_q};
  assign borrow  = trial[DATA_W];
  assign rem_nxt = borrow ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_nxt = {quo_q[DATA_W-2:0], ~borrow};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StFree;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StFree: begin
          if (start_i && !annul_i) begin
            rem_q  <= '0;
            quo_q  <= dvnd_mag;
            dvsr_q <= dvsr_mag;
            cnt_q  <= '0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= dvnd_neg ^ dvsr_neg;
            neg_rem_q <= dvnd_neg;
`endif
            state_q <= (opdata2_i == '0) ? StByZero : StOn;
          end
        end
        StByZero: begin
          if (annul_i) begin
            state_q <= StFree;
          end else begin
            // ready_o follows one edge later from StEnd
            state_q  <= StEnd;
            result_o <= '0;
          end
        end
        StOn: begin
          if (annul_i) begin
            state_q <= StFree;
          end else if (cnt_q == CntW'(DATA_W)) begin
            state_q  <= StEnd;
            result_o <= {rem_fix, quo_fix};
            ready_o  <= 1'b1;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StEnd: begin
          if (!start_i) begin
            state_q  <= StFree;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else begin
            ready_o <= 1'b1;
          end
        end
        default: state_q <= StFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit (DATA_W = 32). Expected results are pushed
// when an operation is driven and popped when ready_o is seen.
module tb_div_unit;

`ifdef DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  logic [63:0] sb_q[$];
  int          n_checks;
  int          n_errors;
  int          n_wait;
  logic [31:0] ra;
  logic [31:0] rb;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after the accept edge: waits for ready_o, checks latency and
  // result, holds in END (annul must be ignored), then releases start.
  task automatic finish_div(input int exp_lat);
    int n;
    logic [63:0] exp;
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    check("result", result, exp);
    annul = 1'b1;
    @(posedge clk); #1;
    check("end_hold_rdy", 64'(ready), 64'd1);
    check("end_hold_res", result, exp);
    annul = 1'b0;
    @(posedge clk); #1;
    check("end_hold2_res", result, exp);
    start = 1'b0;
    @(posedge clk); #1;
    check("drop_rdy", 64'(ready), 64'd0);
    check("drop_res", result, 64'd0);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp);
    opdata1    = a;
    opdata2    = b;
    signed_div = s;
    start      = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    check("accept_busy", 64'(ready), 64'd0);
    // Operands must be captured on the accept edge
    opdata1    = $urandom;
    opdata2    = $urandom;
    signed_div = ~s;
    finish_div((b == 32'd0) ? 2 : 33);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b0;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    opdata1    = '0;
    opdata2    = '0;
    #1;
    check("reset_rdy", 64'(ready), 64'd0);
    check("reset_res", result, 64'd0);
    #21 rst = 1'b1;

    // Directed unsigned cases
    run_div(32'd100, 32'd7, 1'b0, {32'h2, 32'hE});
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF});
    run_div(32'd0, 32'd5, 1'b0, 64'd0);
    run_div(32'd3, 32'd10, 1'b0, {32'h3, 32'h0});
    run_div(32'd77, 32'd77, 1'b0, {32'h0, 32'h1});
    run_div(32'd1234, 32'd0, 1'b0, 64'd0);

    // Signed cases; unsigned interpretation when the feature is absent
    run_div(32'hFFFFFFF9, 32'd2, 1'b1,
            SignedEn ? {32'hFFFFFFFF, 32'hFFFFFFFD} : {32'h1, 32'h7FFFFFFC});
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1,
            SignedEn ? {32'h0, 32'h80000000} : {32'h80000000, 32'h0});
    run_div(32'd7, 32'hFFFFFFFE, 1'b1,
            SignedEn ? {32'h1, 32'hFFFFFFFD} : {32'h7, 32'h0});

    // Random unsigned
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd1;
      run_div(ra, rb, 1'b0, {ra % rb, ra / rb});
    end

    // annul held in FREE blocks acceptance
    opdata1 = 32'd1000; opdata2 = 32'd9; signed_div = 1'b0;
    start = 1'b1; annul = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("annul_free_rdy", 64'(ready), 64'd0);
    end
    annul = 1'b0;
    sb_q.push_back({32'd1, 32'd111});
    @(posedge clk); #1;
    finish_div(33);

    // annul in BYZERO
    opdata1 = 32'd5; opdata2 = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    annul = 1'b1;
    @(posedge clk); #1;
    check("annul_bz_e1", 64'(ready), 64'd0);
    @(posedge clk); #1;
    check("annul_bz_e2", 64'(ready), 64'd0);
    annul = 1'b0;
    sb_q.push_back(64'd0);
    @(posedge clk); #1;
    finish_div(2);

    // annul pulsed at E10 of a division, new start accepted at E12
    opdata1 = 32'd500; opdata2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      check("annul_on_busy", 64'(ready), 64'd0);
    end
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    check("annul_on_e11", 64'(ready), 64'd0);
    opdata1 = 32'd1000; opdata2 = 32'd13;
    sb_q.push_back({32'd12, 32'd76});
    @(posedge clk); #1;
    opdata1 = $urandom; opdata2 = $urandom;
    finish_div(33);

    // async reset while a result is held in END
    opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    n_wait = 0;
    while (!ready && n_wait < 100) begin
      @(posedge clk); #1;
      n_wait++;
    end
    check("rst_pre_rdy", 64'(ready), 64'd1);
    check("rst_pre_res", result, {32'h2, 32'hE});
    #2 rst = 1'b0;
    #1;
    check("rst_async_rdy", 64'(ready), 64'd0);
    check("rst_async_res", result, 64'd0);
    #2 rst = 1'b1;

    // async reset mid-ON, then a fresh operation on the first edge
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("rst_on_rdy", 64'(ready), 64'd0);
    check("rst_on_res", result, 64'd0);
    #2 rst = 1'b1;
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF});

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter DATA_W, default 32: operand width; result width is 2*DATA_W.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 signed_div_i  input  1  1 = signed (two's complement) division, 0 = unsigned.
REQ-005 opdata1_i  input  DATA_W  dividend.
REQ-006 opdata2_i  input  DATA_W  divisor.
REQ-007 start_i  input  1  request; held high by the pipeline until the result is taken.
REQ-008 annul_i  input  1  cancel the operation in flight (exception/flush).
REQ-009 result_o  output  2*DATA_W  {remainder, quotient}: remainder goes to HI, quotient to LO.
REQ-010 ready_o  output  1  result_o valid.

Function
REQ-011 The block SHALL implement the states FREE, BYZERO, ON and END.
REQ-012 FREE: with start_i=1 and annul_i=0, the block SHALL latch the operands and move to BYZERO if opdata2_i==0, else to ON with the iteration counter at 0; otherwise it SHALL stay in FREE.
REQ-013 ON SHALL perform one restoring radix-2 step per cycle (shift, trial subtract of divisor, quotient bit = not borrow).
REQ-014 ON SHALL move to END after exactly DATA_W steps and register result_o.
REQ-015 Latency: take E0 as the accept edge. Steps occur at E1..E(DATA_W), and ready_o=1 from E(DATA_W+1); for DATA_W=32 that is E33.
REQ-016 BYZERO SHALL move to END on the next edge, with result_o = all zeros and ready_o=1 from E2.
REQ-017 END SHALL hold ready_o=1 and result_o stable while start_i=1.
REQ-018 In END, start_i=0 SHALL return the block to FREE with ready_o=0 and result_o=0 on that edge.
REQ-019 annul_i=1 in ON or BYZERO SHALL return the block to FREE on the next edge; ready_o SHALL never assert for an annulled operation.
REQ-020 annul_i in FREE SHALL block acceptance; annul_i in END SHALL have no effect.
REQ-021 Operand changes after the accept edge SHALL NOT affect the result.
REQ-022 ready_o and result_o SHALL be registered outputs.
REQ-023 Unsigned: quotient = floor(a/b) and remainder = a - q*b, both modulo 2^DATA_W.
REQ-024 Signed: the block SHALL divide the magnitudes. The quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-025 Signed most-negative / -1 SHALL give quotient = most-negative (wrap) and remainder = 0.

Reset
REQ-026 rst low SHALL immediately force state FREE, counter 0, ready_o=0 and result_o=0, regardless of clk.
REQ-027 Reset mid-operation SHALL discard the operation; after release, the block SHALL accept a new start on the first edge.

Configuration
REQ-028 With DIV_SIGNED_EN defined, the signed path of REQ-024/REQ-025 SHALL be compiled in and selected by signed_div_i.
REQ-029 Without DIV_SIGNED_EN, signed_div_i SHALL be ignored and every division SHALL be unsigned; no magnitude/negation logic SHALL be built.

Verification
REQ-030 Unsigned 100 / 7 with start held -> ready_o rises at E33 with result_o = {32'h2, 32'hE}; it stays until start_i drops, then returns to 0.
REQ-031 Signed -7 / 2 (DIV_SIGNED_EN) -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}; signed 32'h80000000 / 32'hFFFFFFFF -> {32'h0, 32'h80000000}.
REQ-032 Divisor 0 -> ready_o at E2 with result_o = 64'h0.
REQ-033 annul_i pulsed at E10 of a division -> FREE at E11 with no ready_o; a new start at E12 completes normally at E12+33.
REQ-034 rst asserted asynchronously mid-ON -> outputs zero without a clock edge; after release, 0xFFFFFFFF / 1 -> {32'h0, 32'hFFFFFFFF}.
REQ-035 Without DIV_SIGNED_EN, signed_div_i=1 with -7 / 2 -> unsigned result {32'h1, 32'h7FFFFFFC}.
